// File: rtl/up_down_counter_pkg.sv
// Shared constants and step-decode type for the general-purpose up/down counter.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Action the counter register takes on the coming edge.
    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_INC,
        STEP_DEC,
        STEP_TOP,
        STEP_BOT
    } step_e;

endpackage

// File: rtl/up_down_counter_if.sv
// Control/status bundle between a counter client (master) and the counter (slave).
interface up_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] qOut;
    logic             tc;
    logic             tick;

    modport master (
        output en, up, sat, load, loadVal,
        input  qOut, tc, tick
    );

    modport slave (
        input  en, up, sat, load, loadVal,
        output qOut, tc, tick
    );
endinterface

// File: rtl/up_down_counter_tick_divider.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
module tick_divider #(
    parameter int unsigned PRESCALE = 1,
    parameter int          PS_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PS_WIDTH-1:0] LAST = PS_WIDTH'(PRESCALE - 1);

    if (PRESCALE < 1 || longint'(PRESCALE) > (64'd1 << PS_WIDTH)) begin : g_bad_prescale
        $error("tick_divider: PRESCALE must lie in 1..2**PS_WIDTH");
    end

    logic [PS_WIDTH-1:0] psCnt_q;
    logic [PS_WIDTH-1:0] psCnt_d;

    assign tick = en && (psCnt_q == LAST);

    always_comb begin
        psCnt_d = psCnt_q;
        if (clr) begin
            psCnt_d = '0;
        end else if (en) begin
            psCnt_d = tick ? '0 : psCnt_q + PS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psCnt_q <= '0;
        end else begin
            psCnt_q <= psCnt_d;
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Parametrised up/down counter with load clamp, wrap/saturate boundaries and terminal-count pulse.
module up_down_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1,
    parameter int              PS_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    up_down_counter_if.slave   bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("up_down_counter: WIDTH must lie in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("up_down_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             tick_w;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] load_clamped;
    step_e            step_kind;

    tick_divider #(
        .PRESCALE (PRESCALE),
        .PS_WIDTH (PS_WIDTH)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .en   (bus.en),
        .tick (tick_w)
    );

    assign load_clamped = (bus.loadVal > MAX_VAL) ? MAX_VAL : bus.loadVal;

    // Boundaries are found by explicit compare so MODULUS == 2**WIDTH needs no special case.
    always_comb begin
        step_kind = STEP_HOLD;
        if (bus.load) begin
            step_kind = STEP_LOAD;
        end else if (tick_w) begin
            if (bus.up == DIR_UP) begin
                step_kind = (q_q == MAX_VAL) ? STEP_TOP : STEP_INC;
            end else begin
                step_kind = (q_q == '0) ? STEP_BOT : STEP_DEC;
            end
        end
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        unique case (step_kind)
            STEP_LOAD: q_d = load_clamped;
            STEP_INC:  q_d = q_q + WIDTH'(1);
            STEP_DEC:  q_d = q_q - WIDTH'(1);
            STEP_TOP: begin
                tc_d = 1'b1;
                q_d  = (bus.sat == MODE_SAT) ? q_q : '0;
            end
            STEP_BOT: begin
                tc_d = 1'b1;
                q_d  = (bus.sat == MODE_SAT) ? q_q : MAX_VAL;
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign bus.qOut = q_q;
    assign bus.tc   = tc_q;
    assign bus.tick = tick_w;

endmodule
